// File: rtl/temp_sense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : temp_sense_sequencer
// Brief    : Power-up, settle, discard and average sequencer for the
//            pulse-duration temperature sensor, with a per-sample timeout.
//            Optional build macro TSEQ_AUTO_EN adds a periodic auto-trigger.
// Revision : 1.0 - initial release
// ============================================================================
module temp_sense_sequencer #(
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 8191,
    parameter int PERIOD_CYCLES  = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sample_valid,
    input  logic [12:0] sample,
    output logic        sensor_en,
    output logic        meas_reset_n,
    output logic        busy,
    output logic [12:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        timeout_err
);

    localparam int c_ACC_W  = 13 + AVG_LOG2;
    localparam int c_SCNT_W = AVG_LOG2 + 1;
    localparam int c_SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_SCNT_W-1:0] c_LAST_SMP = c_SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [c_SET_W-1:0]  c_SET_LAST = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_DISCARD = 3'd2,
        S_ACQUIRE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_SET_W-1:0]    r_settle_cnt;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [c_SCNT_W-1:0]   r_smp_cnt;
    logic [c_ACC_W-1:0]    r_acc;
    logic                  w_auto_trig;
    logic                  w_trigger;
    logic                  w_accept;
    logic                  w_sampling;
    logic                  w_tmo_hit;
    logic                  w_last_smp;

`ifdef TSEQ_AUTO_EN
    localparam int c_PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(PERIOD_CYCLES - 1);

    logic [c_PER_W-1:0] r_period_cnt;

    assign w_auto_trig = (r_period_cnt == c_PER_LAST);

    // Restarts on every accepted measurement and on every trigger, even a dropped one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_cnt <= '0;
        end else if (w_accept || w_auto_trig) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end
`else
    // Never fires: PERIOD_CYCLES only matters when the auto-trigger is built in
    assign w_auto_trig = (PERIOD_CYCLES < 0);
`endif

    assign w_trigger  = start | w_auto_trig;
    assign w_accept   = (r_state == S_IDLE) && w_trigger;
    assign w_sampling = (r_state == S_DISCARD) || (r_state == S_ACQUIRE);
    assign w_tmo_hit  = w_sampling && !sample_valid && (r_tmo_cnt == c_TMO_LAST);
    assign w_last_smp = (r_state == S_ACQUIRE) && sample_valid && (r_smp_cnt == c_LAST_SMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle_cnt == c_SET_LAST) w_next = S_DISCARD;
            end
            S_DISCARD: begin
                if (sample_valid)   w_next = S_ACQUIRE;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_ACQUIRE: begin
                if (w_last_smp)     w_next = S_DONE;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_en    <= 1'b0;
            meas_reset_n <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sensor_en    <= (w_next != S_IDLE);
            meas_reset_n <= (w_next == S_DISCARD) || (w_next == S_ACQUIRE) || (w_next == S_DONE);
            busy         <= (w_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;
            r_tmo_cnt    <= (w_sampling && !sample_valid) ? r_tmo_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
        end else if ((r_state == S_ACQUIRE) && sample_valid) begin
            r_acc     <= r_acc + c_ACC_W'(sample);
            r_smp_cnt <= r_smp_cnt + 1'b1;
        end else if (r_state != S_ACQUIRE) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
        end
    end

    // A fresh result in DONE takes priority over a consumer clear in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                result       <= 13'(r_acc >> AVG_LOG2);
                result_valid <= 1'b1;
            end else if (w_accept || result_ready) begin
                result_valid <= 1'b0;
            end

            if (w_tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (w_accept) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temp_sense_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_sense_sequencer
// Brief    : Directed bench for temp_sense_sequencer (AVG_LOG2=2 and 4 units).
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_sense_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, sample_valid, result_ready;
    logic [12:0] sample;
    logic        sensor_en, meas_reset_n, busy, result_valid, timeout_err;
    logic [12:0] result;

    logic        start4, sample_valid4, result_ready4;
    logic [12:0] sample4;
    logic        sensor_en4, meas_reset_n4, busy4, result_valid4, timeout_err4;
    logic [12:0] result4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    temp_sense_sequencer #(
        .AVG_LOG2(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50), .PERIOD_CYCLES(2000)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
        .sample(sample), .sensor_en(sensor_en), .meas_reset_n(meas_reset_n),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .timeout_err(timeout_err)
    );

    temp_sense_sequencer #(
        .AVG_LOG2(4), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sample_valid(sample_valid4),
        .sample(sample4), .sensor_en(sensor_en4), .meas_reset_n(meas_reset_n4),
        .busy(busy4), .result(result4), .result_valid(result_valid4),
        .result_ready(result_ready4), .timeout_err(timeout_err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [12:0] v);
        sample_valid = 1'b1;
        sample       = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sensor_en"},    sensor_en,    0);
        check({tag, " meas_reset_n"}, meas_reset_n, 0);
        check({tag, " busy"},         busy,         0);
        check({tag, " result"},       result,       0);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " timeout_err"},  timeout_err,  0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = '0; result_ready = 1'b0;
        start4 = 1'b0; sample_valid4 = 1'b0; sample4 = '0; result_ready4 = 1'b0;
        tick(3);
        reset = 1'b0;
        check_reset_outputs("reset");

        // Basic run: 999 dropped, (100+101+102+104)/4 = 101
        do_start();
        check("start busy", busy, 1);
        check("start sensor_en", sensor_en, 1);
        check("start meas_reset_n", meas_reset_n, 0);
        tick(3);
        check("settle N+3 meas_reset_n", meas_reset_n, 0);
        tick();
        check("settle N+4 meas_reset_n", meas_reset_n, 1);
        send(13'd999); tick();
        send(13'd100); tick();
        send(13'd101); tick();
        send(13'd102); tick();
        send(13'd104);
        check("last sample busy", busy, 1);
        check("last sample result_valid", result_valid, 0);
        tick();
        check("basic result", result, 101);
        check("basic result_valid", result_valid, 1);
        check("basic done busy", busy, 0);
        check("basic done sensor_en", sensor_en, 0);
        check("basic done meas_reset_n", meas_reset_n, 0);

        // Handshake: hold while not ready, clear one cycle after ready
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold result_valid", result_valid, 1);
            check("hold result", result, 101);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("ready clears result_valid", result_valid, 0);

        // Second run: idle sample ignored, start in ACQUIRE ignored, (10+20+30+41)/4 = 25
        send(13'd5000);
        tick();
        check("idle sample ignored busy", busy, 0);
        do_start();
        tick(4);
        send(13'd7); tick();
        send(13'd10);
        do_start();
        send(13'd20); tick();
        send(13'd30); tick();
        send(13'd41);
        tick();
        check("run2 result", result, 25);
        check("run2 result_valid", result_valid, 1);
        tick();
        check("start while busy not queued", busy, 0);

        // Timeout: 50 cycles in DISCARD with no sample
        do_start();
        check("accept clears result_valid", result_valid, 0);
        tick(53);
        check("pre-timeout timeout_err", timeout_err, 0);
        check("pre-timeout busy", busy, 1);
        tick();
        check("timeout timeout_err", timeout_err, 1);
        check("timeout busy", busy, 0);
        check("timeout sensor_en", sensor_en, 0);
        check("timeout result kept", result, 25);
        check("timeout result_valid", result_valid, 0);
        do_start();
        check("start clears timeout_err", timeout_err, 0);

        // Reset mid-ACQUIRE after two samples
        tick(4);
        send(13'd1); tick();
        send(13'd1000); tick();
        send(13'd1000); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("mid reset");
        do_start();
        tick(4);
        send(13'd0); tick();
        for (int i = 0; i < 4; i++) begin
            send(13'd8); tick();
        end
        check("post-reset result", result, 8);
        check("post-reset result_valid", result_valid, 1);

        // AVG_LOG2=4: 16 max samples, back to back
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(4);
        for (int i = 0; i < 17; i++) begin
            sample_valid4 = 1'b1;
            sample4 = 13'd8191;
            tick();
        end
        sample_valid4 = 1'b0;
        check("max busy before done edge", busy4, 1);
        tick();
        check("max result", result4, 8191);
        check("max result_valid", result_valid4, 1);

`ifdef TSEQ_AUTO_EN
        // Auto trigger every 2000 cycles; a start during busy adds nothing
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(1999);
        check("auto before first trigger", busy, 0);
        tick();
        check("auto first trigger", busy, 1);
        tick(10);
        do_start();
        tick(49);
        check("auto busy start ignored", busy, 0);
        tick(1939);
        check("auto before second trigger", busy, 0);
        tick();
        check("auto second trigger", busy, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
